// File: rtl/psum_pkg.sv
// Shared definitions for the psum scratchpad controller: default sizes,
// controller state encoding and signed saturation limits used when the
// adder is built with PSUM_SAT_EN.
package psum_pkg;

    localparam int PSUM_DEPTH = 24;
    localparam int PSUM_DW    = 16;
    localparam int PSUM_AW    = 5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        ACC_WR    = 3'd2,
        DRAIN_RD  = 3'd3,
        DRAIN_OUT = 3'd4
    } psum_state_e;

    // Largest signed value representable in dw bits (+32767 for dw = 16).
    function automatic logic signed [31:0] psum_sat_max(input int dw);
        return 32'sh7FFF_FFFF >>> (32 - dw);
    endfunction

    // Smallest signed value representable in dw bits (-32768 for dw = 16).
    function automatic logic signed [31:0] psum_sat_min(input int dw);
        return 32'sh8000_0000 >>> (32 - dw);
    endfunction

endpackage

// File: rtl/psum_adder.sv
// Combinational psum update: old scratchpad value plus incoming partial sum.
// Build option: define PSUM_SAT_EN to clamp the signed result to the
// representable range; by default the sum wraps modulo 2^DW.
module psum_adder
    import psum_pkg::*;
#(
    parameter int DW = PSUM_DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum
);

`ifdef PSUM_SAT_EN
    logic [DW:0] wide;

    // Sign-extended add; a disagreement between the top two bits means the
    // signed result left the DW-bit range, so clamp toward the overflow side.
    always_comb begin
        wide = {a[DW-1], a} + {b[DW-1], b};
        if (wide[DW] != wide[DW-1]) begin
            sum = wide[DW] ? DW'(psum_sat_min(DW)) : DW'(psum_sat_max(DW));
        end else begin
            sum = wide[DW-1:0];
        end
    end
`else
    // Two's-complement wrap: carry out of the top bit is discarded.
    always_comb begin
        sum = a + b;
    end
`endif

endmodule

// File: rtl/psum_spad_ctrl.sv
// Partial-sum scratchpad controller: clears, accumulates into, and drains a
// negedge-sampled scratchpad. Saturating accumulate is selected by defining
// PSUM_SAT_EN (see psum_adder); the default build wraps.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting; accepts clr_start > drain_start > accumulate
// CLEAR     | writing 0 to entry idx, one entry per cycle
// ACC_WR    | writing old value + registered data back to registered addr
// DRAIN_RD  | reading entry idx from the scratchpad
// DRAIN_OUT | presenting entry idx on the output stream until accepted
module psum_spad_ctrl
    import psum_pkg::*;
#(
    parameter int DEPTH = PSUM_DEPTH,
    parameter int DW    = PSUM_DW,
    parameter int AW    = PSUM_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cfg_num,
    input  logic          clr_start,
    input  logic          drain_start,
    input  logic          acc_valid,
    output logic          acc_ready,
    input  logic [AW-1:0] acc_addr,
    input  logic [DW-1:0] acc_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic [AW-1:0] spad_addr,
    output logic          spad_we,
    output logic [DW-1:0] spad_din,
    input  logic [DW-1:0] spad_dout,
    output logic          busy,
    output logic          done,
    output logic          err_addr
);

    // Entry counts carry one extra bit so DEPTH = 2^AW would still fit.
    localparam logic [AW:0]   DEPTH_N = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_N   = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_I   = AW'(1);

    psum_state_e   state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   num_q, num_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [AW:0]   cfg_n;
    logic          idx_last;
    logic [DW-1:0] acc_sum;

    psum_adder #(.DW(DW)) u_adder (
        .a   (spad_dout),
        .b   (data_q),
        .sum (acc_sum)
    );

    // Zero or oversized entry counts fall back to the full scratchpad.
    always_comb begin
        cfg_n = {1'b0, cfg_num};
        if (cfg_num == '0 || cfg_n > DEPTH_N) begin
            cfg_n = DEPTH_N;
        end
    end

    assign idx_last  = ({1'b0, idx_q} == (num_q - ONE_N));
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err_addr  = err_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;

    // Next-state, scratchpad port and handshake decode.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        addr_d     = addr_q;
        data_d     = data_q;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
        done_d     = 1'b0;
        err_d      = err_q;
        spad_addr  = '0;
        spad_we    = 1'b0;
        spad_din   = '0;
        acc_ready  = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                acc_ready = !clr_start && !drain_start;
                if (clr_start) begin
                    num_d   = cfg_n;
                    idx_d   = '0;
                    state_d = CLEAR;
                end else if (drain_start) begin
                    num_d   = cfg_n;
                    idx_d   = '0;
                    state_d = DRAIN_RD;
                end else if (acc_valid) begin
                    // Read the old value now; the spad returns it by the next cycle.
                    spad_addr = acc_addr;
                    if ({1'b0, acc_addr} >= cfg_n) begin
                        err_d = 1'b1;
                    end else begin
                        num_d   = cfg_n;
                        addr_d  = acc_addr;
                        data_d  = acc_data;
                        state_d = ACC_WR;
                    end
                end
            end

            CLEAR: begin
                spad_we   = 1'b1;
                spad_addr = idx_q;
                spad_din  = '0;
                if (idx_last) begin
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + ONE_I;
                end
            end

            ACC_WR: begin
                spad_we   = 1'b1;
                spad_addr = addr_q;
                spad_din  = acc_sum;
                state_d   = IDLE;
            end

            DRAIN_RD: begin
                spad_addr  = idx_q;
                out_data_d = spad_dout;
                out_addr_d = idx_q;
                state_d    = DRAIN_OUT;
            end

            DRAIN_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + ONE_I;
                        state_d = DRAIN_RD;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            num_q      <= DEPTH_N;
            addr_q     <= '0;
            data_q     <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_psum_spad_ctrl.sv
// Directed bench for psum_spad_ctrl with a negedge-sampled scratchpad model.
module tb_psum_spad_ctrl;

    localparam int DW = 16;
    localparam int AW = 5;

`ifdef PSUM_SAT_EN
    localparam logic [15:0] OVF_EXP = 16'h7FFF;  // +32767
`else
    localparam logic [15:0] OVF_EXP = 16'h80E8;  // -32536
`endif

    logic          clk;
    logic          reset;
    logic [AW-1:0] cfg_num;
    logic          clr_start;
    logic          drain_start;
    logic          acc_valid;
    logic          acc_ready;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic [AW-1:0] spad_addr;
    logic          spad_we;
    logic [DW-1:0] spad_din;
    logic [DW-1:0] spad_dout;
    logic          busy;
    logic          done;
    logic          err_addr;

    logic [DW-1:0] mem [0:31];
    int            n_checks = 0;
    int            n_errors = 0;
    int            done_cnt = 0;

    psum_spad_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_num     (cfg_num),
        .clr_start   (clr_start),
        .drain_start (drain_start),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .acc_addr    (acc_addr),
        .acc_data    (acc_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .spad_addr   (spad_addr),
        .spad_we     (spad_we),
        .spad_din    (spad_din),
        .spad_dout   (spad_dout),
        .busy        (busy),
        .done        (done),
        .err_addr    (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratchpad: write-first is irrelevant here since dout returns the old word.
    always @(negedge clk) begin
        if (spad_we) mem[spad_addr] <= spad_din;
        spad_dout <= mem[spad_addr];
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input logic [AW-1:0] cfg, input int n, input logic with_drain);
        cfg_num     = cfg;
        clr_start   = 1'b1;
        drain_start = with_drain;
        #1;
        check("clr_acc_ready", acc_ready, 0);
        tick();
        clr_start   = 1'b0;
        drain_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check("clr_we", spad_we, 1);
            check("clr_addr", spad_addr, 32'(i));
            check("clr_din", spad_din, 0);
            check("clr_busy", busy, 1);
            check("clr_done_early", done, 0);
            check("clr_no_out", out_valid, 0);
            tick();
        end
        check("clr_done", done, 1);
        check("clr_busy_end", busy, 0);
        check("clr_we_end", spad_we, 0);
        tick();
        check("clr_done_pulse", done, 0);
    endtask

    task automatic do_acc(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic expect_wr);
        acc_addr  = a;
        acc_data  = d;
        acc_valid = 1'b1;
        #1;
        check("acc_ready", acc_ready, 1);
        check("acc_rd_addr", spad_addr, 32'(a));
        check("acc_rd_we", spad_we, 0);
        tick();
        acc_valid = 1'b0;
        #1;
        if (expect_wr) begin
            check("accwr_ready", acc_ready, 0);
            check("accwr_we", spad_we, 1);
            check("accwr_addr", spad_addr, 32'(a));
            check("accwr_busy", busy, 1);
            tick();
        end else begin
            check("drop_we", spad_we, 0);
            check("drop_busy", busy, 0);
            check("drop_err", err_addr, 1);
        end
    endtask

    task automatic drain_take(input int k, input logic [DW-1:0] exp_d, input logic stall);
        int t = 0;
        out_ready = 1'b0;
        while (!out_valid && t < 10) begin
            tick();
            t++;
        end
        check("drn_valid", out_valid, 1);
        check("drn_data", out_data, 32'(exp_d));
        check("drn_addr", out_addr, 32'(k));
        check("drn_we", spad_we, 0);
        if (stall) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, 32'(exp_d));
            check("stall_addr", out_addr, 32'(k));
            check("stall_done", done, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int dc;
        reset       = 1'b1;
        cfg_num     = '0;
        clr_start   = 1'b0;
        drain_start = 1'b0;
        acc_valid   = 1'b0;
        acc_addr    = '0;
        acc_data    = '0;
        out_ready   = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_spad_we", spad_we, 0);
        check("rst_spad_addr", spad_addr, 0);
        check("rst_spad_din", spad_din, 0);
        check("rst_err", err_addr, 0);
        reset = 1'b0;
        tick();
        check("idle_acc_ready", acc_ready, 1);

        // Full clear, then accumulate 5 + 7 into entry 3.
        do_clear(5'd24, 24, 1'b0);
        check("clr_mem23", mem[23], 0);
        do_acc(5'd3, 16'd5, 1'b1);
        check("acc_mem3_a", mem[3], 5);
        do_acc(5'd3, 16'd7, 1'b1);
        check("acc_mem3_b", mem[3], 12);

        // Overflow: 32000 + 1000.
        do_acc(5'd0, 16'd32000, 1'b1);
        check("ovf_mem0_a", mem[0], 32000);
        do_acc(5'd0, 16'd1000, 1'b1);
        check("ovf_mem0_b", mem[0], 32'(OVF_EXP));

        // cfg_num of 0 and of 31 both mean the full 24 entries.
        cfg_num = 5'd0;
        do_acc(5'd20, 16'd6, 1'b1);
        check("clamp0_mem20", mem[20], 6);
        cfg_num = 5'd31;
        do_acc(5'd23, 16'd1, 1'b1);
        check("clamp31_mem23", mem[23], 1);
        check("clamp_err", err_addr, 0);

        // Simultaneous clear/drain: only the clear runs.
        do_clear(5'd8, 8, 1'b1);
        tick();
        check("prio_no_drain", out_valid, 0);
        check("prio_idle", busy, 0);
        check("prio_mem3", mem[3], 0);
        check("prio_mem20", mem[20], 6);

        // Out-of-range accumulates are dropped and flagged.
        cfg_num = 5'd8;
        do_acc(5'd8, 16'd9, 1'b0);
        do_acc(5'd10, 16'd9, 1'b0);
        check("err_mem8", mem[8], 0);
        check("err_mem10", mem[10], 0);
        tick();
        check("err_sticky", err_addr, 1);

        // Load 1..4 then drain with alternating backpressure.
        cfg_num = 5'd4;
        for (int i = 0; i < 4; i++) do_acc(AW'(i), DW'(i + 1), 1'b1);
        dc = done_cnt;
        cfg_num = 5'd4;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("drn_no_done", done_cnt - dc, 0);
            drain_take(k, DW'(k + 1), (k % 2) == 0);
        end
        check("drn_done", done, 1);
        check("drn_busy_end", busy, 0);
        tick();
        tick();
        check("drn_done_once", done_cnt - dc, 1);

        // Reset after two outputs aborts silently; a new drain starts at 0.
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        drain_take(0, 16'd1, 1'b0);
        drain_take(1, 16'd2, 1'b0);
        dc = done_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_valid", out_valid, 0);
        check("mrst_done", done, 0);
        check("mrst_out_addr", out_addr, 0);
        check("mrst_err", err_addr, 0);
        tick();
        tick();
        check("mrst_no_done", done_cnt - dc, 0);
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        for (int k = 0; k < 4; k++) drain_take(k, DW'(k + 1), 1'b0);
        check("rdrn_done", done, 1);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/psum_spad_ctrl.md
PSUM_SPAD_CTRL -- requirements
Module: psum_spad_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 24, number of psum entries.
REQ-002 SHALL have parameter DW, default 16, psum data width.
REQ-003 SHALL have parameter AW, default 5, address width.
REQ-004 SHALL have port clk, input, 1, the only clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port cfg_num, input, AW, number of psums in use, sampled at each command start.
REQ-007 SHALL have port clr_start, input, 1, pulse to start zeroing entries 0..cfg_num-1.
REQ-008 SHALL have port drain_start, input, 1, pulse to start streaming entries 0..cfg_num-1 out.
REQ-009 SHALL have ports acc_valid (input, 1), acc_ready (output, 1), acc_addr (input, AW) and acc_data (input, DW), the accumulate request handshake.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, DW) and out_addr (output, AW), the drain stream.
REQ-011 SHALL have ports spad_addr (output, AW), spad_we (output, 1), spad_din (output, DW) and spad_dout (input, DW), the scratchpad port; the spad samples on negedge clk.
REQ-012 SHALL have ports busy (output, 1, state != IDLE), done (output, 1, one-cycle pulse at clear/drain completion) and err_addr (output, 1, sticky out-of-range flag).

Function
REQ-013 SHALL implement states IDLE, CLEAR, ACC_WR, DRAIN_RD and DRAIN_OUT.
REQ-014 SHALL clamp the sampled cfg_num to DEPTH when it is 0 or greater than DEPTH.
REQ-015 SHALL, in IDLE, apply start priority clr_start, then drain_start, then acc_valid; starts outside IDLE SHALL be ignored.
REQ-016 SHALL assert acc_ready only in IDLE with no clr_start or drain_start that cycle.
REQ-017 SHALL, on acc_valid&&acc_ready, drive spad_addr=acc_addr with spad_we=0, register acc_addr/acc_data, and go to ACC_WR.
REQ-018 SHALL, in ACC_WR, drive spad_we=1, spad_addr=the registered address and spad_din=spad_dout+the registered data, then return to IDLE, giving 2 cycles per accumulate.
REQ-019 SHALL drop an accepted accumulate whose acc_addr >= the clamped cfg_num (no spad write) and set err_addr; err_addr clears only on reset.
REQ-020 SHALL, in CLEAR, write 0 to address i with spad_we=1 for i=0..N-1, one per cycle (N cycles), then pulse done and go to IDLE.
REQ-021 SHALL, in DRAIN_RD, drive spad_addr=i with spad_we=0, then go to DRAIN_OUT and capture spad_dout into out_data at that posedge.
REQ-022 SHALL, in DRAIN_OUT, hold out_valid=1 with out_data/out_addr=i stable until out_ready; on the handshake it SHALL go to DRAIN_RD with i+1, or after i=N-1 pulse done and go to IDLE.
REQ-023 SHALL, without PSUM_SAT_EN, compute the sum modulo 2^DW (two's-complement wrap).
REQ-024 SHALL keep spad_we=0 in every state except CLEAR and ACC_WR.

Reset
REQ-025 SHALL, on reset, set state=IDLE, the index to 0, busy=0, done=0, out_valid=0, out_data=0, out_addr=0, spad_we=0, spad_addr=0, spad_din=0 and err_addr=0.
REQ-026 SHALL, on reset mid-CLEAR/ACC/DRAIN, abort the operation with no done pulse; spad contents are not restored.

Configuration
REQ-027 SHALL, with PSUM_SAT_EN defined, saturate the signed sum to +32767 / -32768 (DW=16); without it, the sum SHALL wrap.

Structure
REQ-028 SHALL take the state enum, DEPTH/DW/AW defaults and the saturation limits from shared package psum_pkg.
REQ-029 SHALL implement the add and saturate datapath in sub-module psum_adder (combinational, honours PSUM_SAT_EN).

Verification
REQ-030 SHALL verify clear: cfg_num=24, clr_start -> 24 consecutive writes of 0 to addresses 0..23, done pulses on the cycle after the last write, busy=1 throughout.
REQ-031 SHALL verify accumulate: acc_addr=3 with data 5 then 7 after clear -> mem[3]=12; acc_ready=0 in each ACC_WR cycle.
REQ-032 SHALL verify overflow: mem[0]=32000, add 1000 -> mem[0]=-32536 without PSUM_SAT_EN, 32767 with it.
REQ-033 SHALL verify drain backpressure: cfg_num=4, values 1,2,3,4, out_ready toggling -> out_data 1,2,3,4 at out_addr 0..3, each held stable while stalled, single done pulse.
REQ-034 SHALL verify priority and errors: clr_start and drain_start in the same cycle -> CLEAR only; cfg_num=8 with acc_addr=10 -> no write and err_addr=1.
REQ-035 SHALL verify reset mid-drain: reset after 2 outputs -> next cycle IDLE, out_valid=0, no done pulse; a new drain_start restarts at addr 0.
